// File: rtl/apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_slave
// Brief    : APB timer peripheral with prescaler, compare match, level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer_slave #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq_o
);

    localparam int WS_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    localparam logic [4:0] c_addr_ctrl  = 5'h00;
    localparam logic [4:0] c_addr_presc = 5'h04;
    localparam logic [4:0] c_addr_count = 5'h08;
    localparam logic [4:0] c_addr_cmp   = 5'h0C;
    localparam logic [4:0] c_addr_stat  = 5'h10;

    logic [2:0]      ctrl_q,   ctrl_d;
    logic [15:0]     presc_q,  presc_d;
    logic [15:0]     pcnt_q,   pcnt_d;
    logic [31:0]     count_q,  count_d;
    logic [31:0]     cmp_q,    cmp_d;
    logic            match_q,  match_d;
    logic [WS_W-1:0] ws_cnt_q, ws_cnt_d;

    logic       access;
    logic       complete;
    logic       addr_err;
    logic       wr_ok;
    logic       tick;
    logic       hit;
    logic [4:0] offs;

    assign offs     = PADDR[4:0];
    assign addr_err = (|(PADDR >> 5)) || (offs[1:0] != 2'b00) || (offs > c_addr_stat);
    assign access   = PSEL && PENABLE;
    assign PREADY   = access && (ws_cnt_q == WS_W'(WAIT_STATES));
    assign complete = PREADY;
    assign wr_ok    = complete && PWRITE && !addr_err;
    assign PSLVERR  = complete && addr_err;
    assign irq_o    = match_q && ctrl_q[2];

    // Read mux only looks at address and registers, never at PWDATA.
    always_comb begin
        PRDATA = 32'h0;
        if (complete && !addr_err) begin
            case (offs)
                c_addr_ctrl:  PRDATA = {29'h0, ctrl_q};
                c_addr_presc: PRDATA = {16'h0, presc_q};
                c_addr_count: PRDATA = count_q;
                c_addr_cmp:   PRDATA = cmp_q;
                c_addr_stat:  PRDATA = {31'h0, match_q};
                default:      PRDATA = 32'h0;
            endcase
        end
    end

    always_comb begin
        ws_cnt_d = ws_cnt_q;
        if (!PSEL || complete) begin
            ws_cnt_d = '0;
        end else if (access) begin
            ws_cnt_d = ws_cnt_q + WS_W'(1);
        end
    end

    always_comb begin
        tick   = 1'b0;
        pcnt_d = 16'h0;
        if (ctrl_q[0]) begin
            if (pcnt_q == presc_q) begin
                tick = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end
    end

    assign hit = tick && (count_q == cmp_q);

    // Tick effects first, then APB writes override them.
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;

        if (tick) begin
            if (hit) begin
                match_d = 1'b1;
                count_d = 32'h0;
                if (ctrl_q[1]) begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_ok) begin
            case (offs)
                c_addr_ctrl:  ctrl_d  = PWDATA[2:0];
                c_addr_presc: presc_d = PWDATA[15:0];
                c_addr_count: count_d = PWDATA;
                c_addr_cmp:   cmp_d   = PWDATA;
                c_addr_stat: begin
                    if (PWDATA[0] && !hit) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= 3'h0;
            presc_q  <= 16'h0;
            pcnt_q   <= 16'h0;
            count_q  <= 32'h0;
            cmp_q    <= 32'h0;
            match_q  <= 1'b0;
            ws_cnt_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
            ws_cnt_q <= ws_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer_slave
// Brief    : Self-checking bench for apb_timer_slave against a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer_slave;

    localparam int WS = 2;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr, irq;

    always #5 clk = ~clk;

    apb_timer_slave #(
        .APB_ADDR_WIDTH (AW),
        .WAIT_STATES    (WS)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .irq_o   (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] presc;
        logic [15:0] pcnt;
        logic [31:0] count;
        logic [31:0] cmp;
        logic        match;
    } mstate_t;

    mstate_t       m = '0;
    logic          f_fire = 1'b0;
    logic          f_write = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [31:0]   f_data = '0;
    logic          mon_en = 1'b0;

    function automatic bit is_err(input logic [AW-1:0] a);
        return !(a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010});
    endfunction

    function automatic logic [31:0] m_read(input mstate_t s, input logic [AW-1:0] a);
        case (a)
            12'h000: return {29'h0, s.ctrl};
            12'h004: return {16'h0, s.presc};
            12'h008: return s.count;
            12'h00C: return s.cmp;
            12'h010: return {31'h0, s.match};
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the timer as described by its register rules.
    function automatic mstate_t model_next(input mstate_t s, input logic fire, input logic wr,
                                           input logic [AW-1:0] a, input logic [31:0] d);
        mstate_t n = s;
        bit en   = s.ctrl[0];
        bit tick = en && (s.pcnt == s.presc);
        bit hit  = tick && (s.count == s.cmp);
        n.pcnt = (!en || tick) ? 16'h0 : s.pcnt + 16'd1;
        if (hit) begin
            n.match = 1'b1;
            n.count = 0;
            if (s.ctrl[1]) n.ctrl[0] = 1'b0;
        end else if (tick) begin
            n.count = s.count + 1;
        end
        if (fire && wr && !is_err(a)) begin
            case (a)
                12'h000: n.ctrl  = d[2:0];
                12'h004: n.presc = d[15:0];
                12'h008: n.count = d;
                12'h00C: n.cmp   = d;
                12'h010: if (d[0] && !hit) n.match = 1'b0;
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= rst ? mstate_t'(0) : model_next(m, f_fire, f_write, f_addr, f_data);
    end

    // Every non-completion cycle: bus outputs idle; every cycle: irq level.
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            check_eq("irq_level", irq, m.ctrl[2] & m.match);
            if (!f_fire) begin
                check_eq("idle_pready", pready, 0);
                check_eq("idle_prdata", prdata, 0);
                check_eq("idle_pslverr", pslverr, 0);
            end
        end
    end

    task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        rd = 32'h0; err = 1'b0;
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            penable = 1'b1;
            if (k == WS) begin
                #1;
                rd  = prdata;
                err = pslverr;
                check_eq("pready", pready, 1);
                check_eq("pslverr", pslverr, is_err(a));
                if (!wr) check_eq("prdata", prdata, m_read(m, a));
                else if (is_err(a)) check_eq("prdata_err", prdata, 0);
                f_write = wr; f_addr = a; f_data = d; f_fire = 1'b1;
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; f_fire = 1'b0;
    endtask

    task automatic apb_abandon(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          n;
    logic [AW-1:0] addr_tab [9] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                    12'h014, 12'h002, 12'h800, 12'h01C};

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_prdata", prdata, 0);
        check_eq("rst_pready", pready, 0);
        check_eq("rst_pslverr", pslverr, 0);
        check_eq("rst_irq", irq, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apb(1'b0, addr_tab[i], 32'h0, rd, err);
            check_eq("rst_reg", rd, 0);
            check_eq("rst_reg_err", err, 0);
        end

        // Periodic match with prescaler
        apb(1'b1, 12'h00C, 32'd3, rd, err);
        apb(1'b1, 12'h004, 32'd1, rd, err);
        apb(1'b1, 12'h000, 32'h5, rd, err);
        n = 0;
        #1;
        while (irq !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check_eq("match_latency", n, 8);
        apb(1'b0, 12'h008, 32'h0, rd, err);
        apb(1'b1, 12'h000, 32'h0, rd, err);
        apb(1'b1, 12'h010, 32'h1, rd, err);
        apb(1'b1, 12'h008, 32'h0, rd, err);

        // One-shot
        apb(1'b1, 12'h00C, 32'h0, rd, err);
        apb(1'b1, 12'h004, 32'h0, rd, err);
        apb(1'b1, 12'h000, 32'h3, rd, err);
        apb(1'b0, 12'h000, 32'h0, rd, err);
        check_eq("oneshot_ctrl", rd, 32'h2);
        apb(1'b0, 12'h008, 32'h0, rd, err);
        check_eq("oneshot_count", rd, 32'h0);
        apb(1'b0, 12'h010, 32'h0, rd, err);
        check_eq("oneshot_match", rd, 32'h1);
        apb(1'b1, 12'h010, 32'h1, rd, err);

        // Counter wrap gives no flag
        apb(1'b1, 12'h008, 32'hFFFF_FFFF, rd, err);
        apb(1'b1, 12'h00C, 32'd5, rd, err);
        apb(1'b1, 12'h000, 32'h1, rd, err);
        apb(1'b0, 12'h010, 32'h0, rd, err);
        check_eq("wrap_no_match", rd, 32'h0);
        repeat (6) @(negedge clk);
        apb(1'b0, 12'h010, 32'h0, rd, err);
        check_eq("wrap_match", rd, 32'h1);
        apb(1'b0, 12'h008, 32'h0, rd, err);
        apb(1'b1, 12'h000, 32'h0, rd, err);
        apb(1'b1, 12'h010, 32'h1, rd, err);

        // Decode errors
        apb(1'b0, 12'h014, 32'h0, rd, err);
        check_eq("err14_slverr", err, 1);
        check_eq("err14_prdata", rd, 0);
        apb(1'b0, 12'h002, 32'h0, rd, err);
        check_eq("err02_slverr", err, 1);
        apb(1'b1, 12'h800, 32'h7, rd, err);
        check_eq("err800_slverr", err, 1);
        apb(1'b0, 12'h000, 32'h0, rd, err);
        check_eq("err_ctrl_kept", rd, 32'h0);
        apb(1'b0, 12'h00C, 32'h0, rd, err);
        check_eq("err_cmp_kept", rd, 32'd5);

        // W1C racing a match every cycle
        apb(1'b1, 12'h00C, 32'h0, rd, err);
        apb(1'b1, 12'h008, 32'h0, rd, err);
        apb(1'b1, 12'h000, 32'h5, rd, err);
        apb(1'b1, 12'h010, 32'h1, rd, err);
        apb(1'b0, 12'h010, 32'h0, rd, err);
        check_eq("w1c_race_match", rd, 32'h1);
        apb(1'b1, 12'h000, 32'h4, rd, err);
        #1;
        check_eq("irq_before_w1c", irq, 1);
        apb(1'b1, 12'h010, 32'h1, rd, err);
        #1;
        check_eq("irq_after_w1c", irq, 0);

        // Abandoned transfer has no side effect
        apb_abandon(12'h00C, 32'h77);
        apb(1'b0, 12'h00C, 32'h0, rd, err);
        check_eq("abandon_cmp", rd, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            bit            w;
            a = addr_tab[$urandom_range(0, 8)];
            w = ($urandom_range(0, 1) == 1);
            case (a)
                12'h000: d = $urandom_range(0, 7);
                12'h004: d = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0, 16'($urandom_range(0, 3))};
                12'h008: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 8));
                12'h00C: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 10));
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) apb_abandon(a, d);
            else apb(w, a, d, rd, err);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int i = 0; i < 5; i++) apb(1'b0, addr_tab[i], 32'h0, rd, err);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
